// File: rtl/seg_pkg.sv
// Shared types, segment codes and the BCD-to-segment decoder for the scanned display.
package seg_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned BCD_DIGITS = 5;
  localparam int unsigned VALUE_W    = 14;
  localparam int unsigned BCD_W      = 4 * BCD_DIGITS;

  typedef enum logic [1:0] {LOAD, SHIFT, COMMIT} conv_state_e;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] nib);
    case (nib)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Free-running 16-cycle double-dabble converter: LOAD, 14 x SHIFT, COMMIT.
module bin2bcd_seq
  import seg_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [VALUE_W-1:0] i_value,
  output logic [BCD_W-1:0]   o_bcd,
  output logic               o_commit
);

  localparam logic [3:0] LastShift = 4'(VALUE_W - 1);

  conv_state_e        r_state;
  conv_state_e        w_state_d;
  logic [VALUE_W-1:0] r_bin;
  logic [BCD_W-1:0]   r_acc;
  logic [BCD_W-1:0]   w_adj;
  logic [3:0]         r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= LOAD;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      LOAD:    w_state_d = SHIFT;
      SHIFT:   if (r_cnt == LastShift) w_state_d = COMMIT;
      COMMIT:  w_state_d = LOAD;
      default: w_state_d = LOAD;
    endcase
  end

  // Add-3 correction wraps inside each nibble
  always_comb begin
    w_adj = r_acc;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (r_acc[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bin <= '0;
      r_acc <= '0;
      r_cnt <= '0;
    end else begin
      case (r_state)
        LOAD: begin
          r_bin <= i_value;
          r_acc <= '0;
          r_cnt <= '0;
        end
        SHIFT: begin
          r_acc <= {w_adj[BCD_W-2:0], r_bin[VALUE_W-1]};
          r_bin <= {r_bin[VALUE_W-2:0], 1'b0};
          r_cnt <= r_cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign o_bcd    = r_acc;
  assign o_commit = (r_state == COMMIT);

endmodule

// File: rtl/seg_scan_display.sv
// Scanned 8-digit seven-segment driver showing a 14-bit count as 5 decimal digits.
// Optional LEAD_ZERO_BLANK_EN blanks leading zeros on digits 4..1.
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned SCAN_HZ = 1000
) (
  input  logic                  clk_disp,
  input  logic                  rst,
  input  logic [VALUE_W-1:0]    value,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp
);

  localparam int unsigned SLOT    = CLK_HZ / (SCAN_HZ * NUM_DIGITS);
  localparam int unsigned PreW    = $clog2(SLOT);
  localparam logic [PreW-1:0] PreLast = PreW'(SLOT - 1);

  logic [BCD_W-1:0]      w_bcd;
  logic                  w_commit;
  logic [BCD_W-1:0]      r_disp_bcd;
  logic [PreW-1:0]       r_pre;
  logic [2:0]            r_idx;
  logic [NUM_DIGITS-1:0] r_an;
  logic [6:0]            r_seg;
  logic [NUM_DIGITS-1:0] w_an;
  logic [6:0]            w_seg;
  logic [BCD_DIGITS-1:0] w_blank;

  bin2bcd_seq u_conv (
    .i_clk    (clk_disp),
    .i_rst    (rst),
    .i_value  (value),
    .o_bcd    (w_bcd),
    .o_commit (w_commit)
  );

`ifdef LEAD_ZERO_BLANK_EN
  // A digit is blank when it and every more significant digit are zero
  always_comb begin
    w_blank = '0;
    for (int i = 1; i < BCD_DIGITS; i++) begin
      w_blank[i] = ((r_disp_bcd >> (4 * i)) == '0);
    end
  end
`else
  assign w_blank = '0;
`endif

  always_comb begin
    w_an  = '1;
    w_seg = SEG_BLANK;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (r_idx == 3'(i) && !w_blank[i]) begin
        w_an[i] = 1'b0;
        w_seg   = bcd_to_seg(r_disp_bcd[4*i +: 4]);
      end
    end
  end

  always_ff @(posedge clk_disp) begin
    if (rst) begin
      r_disp_bcd <= '0;
      r_pre      <= '0;
      r_idx      <= '0;
      r_an       <= '1;
      r_seg      <= SEG_BLANK;
    end else begin
      if (w_commit) r_disp_bcd <= w_bcd;
      if (r_pre == PreLast) begin
        r_pre <= '0;
        r_idx <= r_idx + 3'd1;
      end else begin
        r_pre <= r_pre + 1'b1;
      end
      r_an  <= w_an;
      r_seg <= w_seg;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_seg_scan_display.sv
// Randomized bench for seg_scan_display against a cycle-timeline model of the display.
module tb_seg_scan_display;

  localparam int unsigned CLK_HZ  = 8000;
  localparam int unsigned SCAN_HZ = 125;
  localparam int          SLOT    = 8;
`ifdef LEAD_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk_disp = 1'b0;
  logic        rst      = 1'b1;
  logic [13:0] value    = '0;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;

  seg_scan_display #(
    .CLK_HZ  (CLK_HZ),
    .SCAN_HZ (SCAN_HZ)
  ) dut (
    .clk_disp (clk_disp),
    .rst      (rst),
    .value    (value),
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

  always #5 clk_disp = ~clk_disp;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned hist[$];  // value presented at each post-reset edge
  int          k = 0;    // edges taken since reset release
  int unsigned seg_tab[10] = '{'h40, 'h79, 'h24, 'h30, 'h19, 'h12, 'h02, 'h78, 'h00, 'h10};
  int unsigned pow10[5]    = '{1, 10, 100, 1000, 10000};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", tag, obs, exp, k);
    end
  endtask

  // Number on display before edge kk: the sample of the last completed 16-cycle pass
  function automatic int unsigned shown_val(input int kk);
    if (kk < 16) return 0;
    return hist[((kk - 16) / 16) * 16];
  endfunction

  function automatic logic [31:0] to_bcd(input int unsigned v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 5; i++) r[4*i +: 4] = 4'((v / pow10[i]) % 10);
    return r;
  endfunction

  task automatic check_cycle();
    int          kk;
    int          idx;
    int unsigned v;
    logic [7:0]  exp_an;
    logic [6:0]  exp_seg;
    kk      = k - 1;
    idx     = (kk / SLOT) % 8;
    v       = shown_val(kk);
    exp_an  = 8'hFF;
    exp_seg = 7'h7F;
    if (idx < 5 && !(LZB && idx > 0 && v < pow10[idx])) begin
      exp_an  = ~(8'd1 << idx);
      exp_seg = 7'(seg_tab[(v / pow10[idx]) % 10]);
    end
    check_eq("an", 32'(an), 32'(exp_an));
    check_eq("seg", 32'(seg), 32'(exp_seg));
    check_eq("dp", 32'(dp), 32'd1);
    check_eq("disp_bcd", 32'(dut.r_disp_bcd), to_bcd(shown_val(kk + 1)));
  endtask

  task automatic step(input logic [13:0] v);
    value = v;
    hist.push_back(32'(v));
    @(posedge clk_disp);
    k++;
    @(negedge clk_disp);
    check_cycle();
  endtask

  task automatic hold(input logic [13:0] v, input int n);
    repeat (n) step(v);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) begin
      @(posedge clk_disp);
      @(negedge clk_disp);
      check_eq("rst_an", 32'(an), 32'hFF);
      check_eq("rst_seg", 32'(seg), 32'h7F);
      check_eq("rst_dp", 32'(dp), 32'd1);
      check_eq("rst_disp", 32'(dut.r_disp_bcd), 32'd0);
    end
    rst = 1'b0;
    hist.delete();
    k = 0;
  endtask

  initial begin
    logic [13:0] cur;
    int          bvals[7] = '{9, 10, 99, 100, 9999, 10000, 0};

    do_reset(3);

    // Scan order with full-scale value
    hold(14'd16383, 16 + 2 * 8 * SLOT);

    // Decimal boundaries, then zero for leading-zero behaviour
    foreach (bvals[i]) hold(14'(bvals[i]), 32 + 8 * SLOT);

    // Change on the 5th SHIFT cycle must not tear the displayed value
    hold(14'd1234, 32);
    while (k % 16 != 5) step(14'd1234);
    hold(14'd5678, 48);

    // 0 -> 9 just after LOAD
    hold(14'd0, 32);
    while (k % 16 != 1) step(14'd0);
    hold(14'd9, 40);

    cur = 14'($urandom_range(0, 16383));
    repeat (600) begin
      if ($urandom_range(0, 7) == 0) cur = 14'($urandom_range(0, 16383));
      step(cur);
    end

    // Reset pulse in the middle of a SHIFT run
    hold(14'd500, 20);
    while (k % 16 != 6) step(14'd500);
    value = 14'd500;
    do_reset(1);
    hold(14'd500, 48);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
